// File: rtl/guess_pkg.sv
// Shared types for the guess-number sequencer: FSM states and digit button encoding.
package guess_pkg;

    localparam int DIGIT_W = 2;

    typedef logic [DIGIT_W-1:0] digit_code_t;

    localparam digit_code_t CODE_I1 = 2'd0;
    localparam digit_code_t CODE_I2 = 2'd1;
    localparam digit_code_t CODE_I3 = 2'd2;
    localparam digit_code_t CODE_I4 = 2'd3;

    typedef enum logic [2:0] {
        S_SECRET,
        S_GUESS,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    // Lowest-numbered button wins when several digit edges land in one cycle.
    function automatic digit_code_t prio_code(input logic [3:0] ev);
        if (ev[0])      return CODE_I1;
        else if (ev[1]) return CODE_I2;
        else if (ev[2]) return CODE_I3;
        else            return CODE_I4;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button conditioner: SYNC_STAGES-flop synchroniser followed by a rising-edge detector.
// rise_o is a single-cycle pulse per press; a held button never re-fires.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-number sequencer: conditions buttons, issues digit/load commands, scores compares.
// Optional guess timeout enabled by defining GUESS_TIMEOUT_EN.
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int MAX_DIGITS  = 5,
    parameter int MAX_GUESSES = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000,
    localparam int LEN_W      = $clog2(MAX_DIGITS + 1),
    localparam int ATT_W      = $clog2(MAX_GUESSES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              I1,
    input  logic              I2,
    input  logic              I3,
    input  logic              I4,
    input  logic              enter,
    input  logic              cmp_equal,
    input  logic              cmp_bigger,
    input  logic              cmp_smaller,
    output logic              digit_valid,
    output logic [DIGIT_W-1:0] digit_code,
    output logic [LEN_W-1:0]  entry_len,
    output logic              load_secret,
    output logic              load_guess,
    output logic              clear_entry,
    output logic              equal,
    output logic              bigger,
    output logic              smaller,
    output logic [ATT_W-1:0]  attempts_left,
    output logic              win,
    output logic              lose
);

    logic [4:0] btn_raw;
    logic [4:0] ev;

    assign btn_raw = {enter, I4, I3, I2, I1};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_i   (btn_raw[g]),
            .rise_o  (ev[g])
        );
    end

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ATT_W-1:0]  att_q, att_d;
    digit_code_t       code_q, code_d;
    logic              dv_q, dv_d;
    logic              ls_q, ls_d;
    logic              lg_q, lg_d;
    logic              ce_q, ce_d;
    logic [2:0]        res_q, res_d;   // {equal, bigger, smaller}
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic              guess_wrong;
    logic              timeout;

`ifdef GUESS_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    assign timeout = (state_q == S_GUESS) && !(|ev) &&
                     (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    always_comb begin
        idle_d = idle_q + 1'b1;
        if (state_q != S_GUESS || (|ev) || timeout)
            idle_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        att_d       = att_q;
        code_d      = code_q;
        res_d       = res_q;
        win_d       = win_q;
        lose_d      = lose_q;
        dv_d        = 1'b0;
        ls_d        = 1'b0;
        lg_d        = 1'b0;
        ce_d        = 1'b0;
        guess_wrong = 1'b0;

        case (state_q)
            S_SECRET, S_GUESS: begin
                // enter shadows any digit edge in the same cycle, even when it is ignored
                if (ev[4]) begin
                    if (len_q != '0) begin
                        ce_d  = 1'b1;
                        len_d = '0;
                        if (state_q == S_SECRET) begin
                            ls_d    = 1'b1;
                            state_d = S_GUESS;
                        end else begin
                            lg_d    = 1'b1;
                            state_d = S_CHECK;
                        end
                    end
                end else if (|ev[3:0]) begin
                    if (len_q < LEN_W'(MAX_DIGITS)) begin
                        dv_d   = 1'b1;
                        code_d = prio_code(ev[3:0]);
                        len_d  = len_q + 1'b1;
                    end
                end else if (timeout) begin
                    ce_d        = 1'b1;
                    len_d       = '0;
                    res_d       = '0;
                    guess_wrong = 1'b1;
                end
            end
            S_CHECK: begin
                res_d = {cmp_equal, cmp_bigger, cmp_smaller};
                if (cmp_equal) begin
                    win_d   = 1'b1;
                    state_d = S_WIN;
                end else begin
                    guess_wrong = 1'b1;
                end
            end
            default: ;
        endcase

        if (guess_wrong) begin
            att_d = att_q - 1'b1;
            if (att_q == ATT_W'(1)) begin
                lose_d  = 1'b1;
                state_d = S_LOSE;
            end else begin
                state_d = S_GUESS;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SECRET;
            len_q   <= '0;
            att_q   <= ATT_W'(MAX_GUESSES);
            code_q  <= CODE_I1;
            dv_q    <= 1'b0;
            ls_q    <= 1'b0;
            lg_q    <= 1'b0;
            ce_q    <= 1'b0;
            res_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            att_q   <= att_d;
            code_q  <= code_d;
            dv_q    <= dv_d;
            ls_q    <= ls_d;
            lg_q    <= lg_d;
            ce_q    <= ce_d;
            res_q   <= res_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    assign digit_valid   = dv_q;
    assign digit_code    = code_q;
    assign entry_len     = len_q;
    assign load_secret   = ls_q;
    assign load_guess    = lg_q;
    assign clear_entry   = ce_q;
    assign equal         = res_q[2];
    assign bigger        = res_q[1];
    assign smaller       = res_q[0];
    assign attempts_left = att_q;
    assign win           = win_q;
    assign lose          = lose_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: table of button presses with expected outputs, plus reset/hold sequences.
module tb_guess_game_ctrl;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0, enter = 1'b0;
    logic       cmp_equal = 1'b0, cmp_bigger = 1'b0, cmp_smaller = 1'b0;
    logic       digit_valid, load_secret, load_guess, clear_entry;
    logic [1:0] digit_code;
    logic [2:0] entry_len;
    logic [1:0] attempts_left;
    logic       equal, bigger, smaller, win, lose;

    always #5 clk = ~clk;

    guess_game_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
        .cmp_equal(cmp_equal), .cmp_bigger(cmp_bigger), .cmp_smaller(cmp_smaller),
        .digit_valid(digit_valid), .digit_code(digit_code), .entry_len(entry_len),
        .load_secret(load_secret), .load_guess(load_guess), .clear_entry(clear_entry),
        .equal(equal), .bigger(bigger), .smaller(smaller),
        .attempts_left(attempts_left), .win(win), .lose(lose)
    );

    int n_vec = 0, n_bad = 0;
    int cnt_dv = 0, cnt_ls = 0, cnt_lg = 0, cnt_ce = 0;
    int last_code = 0;

    always @(negedge clk) begin
        if (digit_valid) begin cnt_dv++; last_code = int'(digit_code); end
        if (load_secret) cnt_ls++;
        if (load_guess)  cnt_lg++;
        if (clear_entry) cnt_ce++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // btn bit0..3 = I1..I4, bit4 = enter; hold for 'hold' cycles, then release and settle
    task automatic press(input logic [4:0] b, input int hold);
        @(posedge clk); #1 {enter, I4, I3, I2, I1} = b;
        repeat (hold) @(posedge clk);
        #1 {enter, I4, I3, I2, I1} = 5'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [4:0] btn;
        logic [2:0] cmp;   // {equal, bigger, smaller}
        int         len;
        int         att;
        logic [2:0] res;
        logic [1:0] wl;    // {win, lose}
        int         dv;
        int         ls;
        int         lg;
        int         code;  // -1: not checked
    } vec_t;

    vec_t tbl[$];

    localparam logic [4:0] B1 = 5'b00001, B2 = 5'b00010, B3 = 5'b00100,
                           B4 = 5'b01000, BE = 5'b10000;

    function automatic vec_t v(bit rst, logic [4:0] btn, logic [2:0] cmp, int len, int att,
                               logic [2:0] res, logic [1:0] wl, int dv, int ls, int lg, int code);
        vec_t r;
        r.rst = rst; r.btn = btn; r.cmp = cmp; r.len = len; r.att = att; r.res = res;
        r.wl = wl; r.dv = dv; r.ls = ls; r.lg = lg; r.code = code;
        return r;
    endfunction

    initial begin
        int dv0, ls0, lg0, ce0;

        // Game 1: secret 1234, first guess equal
        tbl.push_back(v(1, B1, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B2, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B3, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, B4, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, BE, 3'b000, 0, 3, 3'b000, 2'b00, 0, 1, 0, -1));
        tbl.push_back(v(0, B1, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B2, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B3, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, B4, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, BE, 3'b100, 0, 3, 3'b100, 2'b10, 0, 0, 1, -1));
        tbl.push_back(v(0, B2, 3'b000, 0, 3, 3'b100, 2'b10, 0, 0, 0, -1));
        // Game 2: secret 42413, one smaller then equal
        tbl.push_back(v(1, B4, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B2, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B4, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B1, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B3, 3'b000, 5, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, BE, 3'b000, 0, 3, 3'b000, 2'b00, 0, 1, 0, -1));
        tbl.push_back(v(0, B4, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B2, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B4, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B1, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, BE, 3'b001, 0, 2, 3'b001, 2'b00, 0, 0, 1, -1));
        tbl.push_back(v(0, B4, 3'b000, 1, 2, 3'b001, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B2, 3'b000, 2, 2, 3'b001, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B4, 3'b000, 3, 2, 3'b001, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B1, 3'b000, 4, 2, 3'b001, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B3, 3'b000, 5, 2, 3'b001, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, BE, 3'b100, 0, 2, 3'b100, 2'b10, 0, 0, 1, -1));
        // Game 3: secret 14321, three wrong guesses -> lose, then dead
        tbl.push_back(v(1, B1, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B4, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B3, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, B2, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B1, 3'b000, 5, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, BE, 3'b000, 0, 3, 3'b000, 2'b00, 0, 1, 0, -1));
        tbl.push_back(v(0, B1, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, BE, 3'b010, 0, 2, 3'b010, 2'b00, 0, 0, 1, -1));
        tbl.push_back(v(0, B2, 3'b000, 1, 2, 3'b010, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, BE, 3'b001, 0, 1, 3'b001, 2'b00, 0, 0, 1, -1));
        tbl.push_back(v(0, B3, 3'b000, 1, 1, 3'b001, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, BE, 3'b010, 0, 0, 3'b010, 2'b01, 0, 0, 1, -1));
        tbl.push_back(v(0, B1, 3'b000, 0, 0, 3'b010, 2'b01, 0, 0, 0, -1));
        tbl.push_back(v(0, BE, 3'b100, 0, 0, 3'b010, 2'b01, 0, 0, 0, -1));
        // Priority and length saturation
        tbl.push_back(v(1, B1 | B3, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, B2 | B4, 3'b000, 2, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B3 | B4, 3'b000, 3, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, B4, 3'b000, 4, 3, 3'b000, 2'b00, 1, 0, 0, 3));
        tbl.push_back(v(0, B2, 3'b000, 5, 3, 3'b000, 2'b00, 1, 0, 0, 1));
        tbl.push_back(v(0, B1, 3'b000, 5, 3, 3'b000, 2'b00, 0, 0, 0, -1));
        // enter on empty entry; enter with a digit in the same cycle
        tbl.push_back(v(1, BE, 3'b000, 0, 3, 3'b000, 2'b00, 0, 0, 0, -1));
        tbl.push_back(v(0, B1, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, BE | B2, 3'b000, 0, 3, 3'b000, 2'b00, 0, 1, 0, -1));
        tbl.push_back(v(0, BE, 3'b000, 0, 3, 3'b000, 2'b00, 0, 0, 0, -1));
        tbl.push_back(v(0, B3, 3'b000, 1, 3, 3'b000, 2'b00, 1, 0, 0, 2));
        tbl.push_back(v(0, BE | B4, 3'b010, 0, 2, 3'b010, 2'b00, 0, 0, 1, -1));

        // Reset state, checked while reset_n is still low
        #12;
        check("rst len", int'(entry_len), 0);
        check("rst att", int'(attempts_left), 3);
        check("rst res", int'({equal, bigger, smaller}), 0);
        check("rst wl", int'({win, lose}), 0);
        check("rst pulses", int'({digit_valid, load_secret, load_guess, clear_entry}), 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            dv0 = cnt_dv; ls0 = cnt_ls; lg0 = cnt_lg; ce0 = cnt_ce;
            {cmp_equal, cmp_bigger, cmp_smaller} = tbl[i].cmp;
            press(tbl[i].btn, 4);
            check($sformatf("v%0d entry_len", i), int'(entry_len), tbl[i].len);
            check($sformatf("v%0d attempts_left", i), int'(attempts_left), tbl[i].att);
            check($sformatf("v%0d eq/bg/sm", i), int'({equal, bigger, smaller}), int'(tbl[i].res));
            check($sformatf("v%0d win/lose", i), int'({win, lose}), int'(tbl[i].wl));
            check($sformatf("v%0d digit_valid cnt", i), cnt_dv - dv0, tbl[i].dv);
            check($sformatf("v%0d load_secret cnt", i), cnt_ls - ls0, tbl[i].ls);
            check($sformatf("v%0d load_guess cnt", i), cnt_lg - lg0, tbl[i].lg);
            check($sformatf("v%0d clear_entry cnt", i), cnt_ce - ce0, tbl[i].ls + tbl[i].lg);
            if (tbl[i].code >= 0)
                check($sformatf("v%0d digit_code", i), last_code, tbl[i].code);
        end
        {cmp_equal, cmp_bigger, cmp_smaller} = 3'b000;

        // Async reset in S_GUESS with three digits entered
        do_reset();
        press(B1, 4);
        press(BE, 4);
        press(B1, 4);
        press(B2, 4);
        press(B3, 4);
        check("pre-reset len", int'(entry_len), 3);
        ls0 = cnt_ls; lg0 = cnt_lg;
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("async len", int'(entry_len), 0);
        check("async att", int'(attempts_left), 3);
        check("async res", int'({equal, bigger, smaller}), 0);
        check("async wl", int'({win, lose}), 0);
        check("async pulses", int'({digit_valid, load_secret, load_guess, clear_entry}), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("no load on reset ls", cnt_ls - ls0, 0);
        check("no load on reset lg", cnt_lg - lg0, 0);
        press(B2, 4);
        press(BE, 4);
        check("after reset secret load", cnt_ls - ls0, 1);
        check("after reset att", int'(attempts_left), 3);

        // Long hold gives one event only
        dv0 = cnt_dv;
        press(B3, 30);
        check("long hold pulses", cnt_dv - dv0, 1);
        check("long hold len", int'(entry_len), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
